// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake bundle between the EX stage and the iterative M-extension unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
//
// state  | meaning
// IDLE   | waiting for start; decodes special cases and latches magnitudes
// CALC   | one multiply/divide iteration per cycle, busy=1
// DONE   | result valid, done pulse for one cycle, then back to IDLE
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_neg;
    logic              r_neg_rem;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // Operand decode for the request presented in IDLE
    logic              w_in_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN-1:0]   w_spec_val;

    always_comb begin
        w_in_div   = bus.funct3[2];
        w_a_signed = w_in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        w_b_signed = w_in_div ? ~bus.funct3[0] : ~bus.funct3[1];
        w_a_neg    = w_a_signed & bus.op_a[XLEN-1];
        w_b_neg    = w_b_signed & bus.op_b[XLEN-1];
        w_a_mag    = w_a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
        w_b_mag    = w_b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
        w_div_zero = w_in_div & (bus.op_b == '0);
        w_div_ovf  = w_in_div & ~bus.funct3[0] & (bus.op_a == MIN_NEG) & (bus.op_b == '1);
        w_spec_val = '0;
        if (w_div_zero) begin
            w_spec_val = bus.funct3[1] ? bus.op_a : '1;
        end else if (w_div_ovf) begin
            w_spec_val = bus.funct3[1] ? '0 : bus.op_a;
        end
    end

    // One iteration of the shared datapath: {r_hi,r_lo} is product or {remainder,quotient}
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
        if (r_funct3[2]) begin
            w_hi_nx = w_ge ? (w_shift[XLEN-1:0] - r_b) : w_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod = {w_hi_nx, w_lo_nx};
        if (r_neg) begin
            w_prod = ~w_prod + 1'b1;
        end
        w_quo = r_neg ? (~w_lo_nx + 1'b1) : w_lo_nx;
        w_rem = r_neg_rem ? (~w_hi_nx + 1'b1) : w_hi_nx;
        case (r_funct3)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_funct3  <= bus.funct3;
                        r_hi      <= '0;
                        r_lo      <= w_a_mag;
                        r_b       <= w_b_mag;
                        r_neg     <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_spec_val;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN);
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_final;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit at XLEN=32: results, latency, busy profile, reset abort.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] sb_q[$];

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] as64, bs64, au64, bu64, p;
        logic signed [31:0] sa, sb;
        as64 = {{32{a[31]}}, a};
        bs64 = {{32{b[31]}}, b};
        au64 = {32'h0, a};
        bu64 = {32'h0, b};
        sa = a;
        sb = b;
        p  = '0;
        case (f)
            3'd0: begin p = as64 * bs64; return p[31:0]; end
            3'd1: begin p = as64 * bs64; return p[63:32]; end
            3'd2: begin p = as64 * bu64; return p[63:32]; end
            3'd3: begin p = au64 * bu64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op; pulse_at>0 re-asserts start with junk operands in that cycle
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input bit spec,
                          input int pulse_at);
        int lat, busy_cnt;
        bit got;
        logic [31:0] e;
        sb_q.push_back(expv);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
        lat = 0; busy_cnt = 0; got = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (c == pulse_at) begin
                bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd9; bus.op_b = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                lat = c;
                got = 1'b1;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), spec ? 32'd1 : 32'd33);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), spec ? 32'd0 : 32'd32);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_result"}, bus.result, e);
        end
        @(negedge clk);
        chk({tag, "_done_single"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_result_hold"}, bus.result, expv);
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.op_a = '0; bus.op_b = '0;

        // Reset state, with start asserted to show reset wins
        repeat (3) @(posedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 0);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1'b0, 0);
        run_op("mul_zero", 3'b000, 32'h1234_5678, 32'd0,        32'd0,         1'b0, 0);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0, 0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0, 0);
        run_op("divu",   3'b101, 32'd100,        32'd7,          32'd14,        1'b0, 0);
        run_op("remu",   3'b111, 32'd100,        32'd7,          32'd2,         1'b0, 0);
        run_op("div_by0",  3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, 0);
        run_op("remu_by0", 3'b111, 32'd5,          32'd0,          32'd5,         1'b1, 0);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 0);
        run_op("divu_ign", 3'b101, 32'd100,        32'd7,          32'd14,        1'b0, 10);

        // Random non-special ops against the reference model
        for (int i = 0; i < 6; i++) begin
            rf = 3'(i + 1);
            ra = $urandom;
            rb = $urandom | 32'd1;
            if (rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_op("rand", rf, ra, rb, model(rf, ra, rb), 1'b0, 0);
        end

        // start held high through DONE: second op accepted only from IDLE
        sb_q.push_back(32'd14);
        sb_q.push_back(32'd15);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk);
        cyc = 0; seen = 1'b0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (c == 33) begin
                chk("hold_done1", {31'b0, bus.done}, 32'd1);
                chk("hold_res1", bus.result, sb_q.pop_front());
                bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd5;
            end
            if (c == 34) begin
                chk("hold_idle_busy", {31'b0, bus.busy}, 32'd0);
                chk("hold_idle_done", {31'b0, bus.done}, 32'd0);
            end
            if (c == 35) bus.start = 1'b0;
            if (c > 33 && bus.done === 1'b1) begin
                cyc = c;
                seen = 1'b1;
            end
        end
        bus.start = 1'b0;
        chk("hold_done2_cycle", 32'(cyc), 32'd67);
        chk("hold_res2", bus.result, sb_q.pop_front());

        // Reset mid-operation abandons the op
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd7; bus.op_b = 32'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 12) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width; successor to the single-cycle ALU control/ALU path.
- Executes all eight M-extension ops selected by funct3, using a start/busy/done handshake.
- Sits beside the main ALU in EX. The core stalls while busy=1 and captures result when done=1.

Parameters:
- XLEN, 32, operand/result width in bits (must be >= 4).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 operand (multiplicand / dividend).
- op_b  input  XLEN  rs2 operand (multiplier / divisor).
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  XLEN  registered result; holds until the next accepted start.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, result=0; counter and internal registers cleared. rst has priority over everything, including start and an operation in progress. Reset mid-operation abandons the operation and produces no done pulse.
- States: IDLE, CALC, DONE.
  - IDLE: if start=1, latch funct3/op_a/op_b.
    - Special case → DONE directly.
    - Otherwise → CALC, with counter=XLEN and busy=1 from the next cycle.
  - CALC: one iteration per cycle; counter decrements; at the counter=1 iteration → DONE.
  - DONE: done=1, busy=0, result updated in the same edge that entered DONE; next cycle → IDLE.
- start in DONE is ignored (accepted only in IDLE). start while busy=1 is ignored; latched operands are unaffected.
- Latency, counting the start edge as cycle 0:
  - Normal ops: done=1 in cycle XLEN+1.
  - Special cases: done=1 in cycle 1.
  - Back-to-back throughput: one op per XLEN+2 cycles.
- Multiply (shift-add, XLEN iterations, 2*XLEN-bit product):
  - Operands are converted to magnitudes per signedness: MUL/MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - The product is negated at the end if the sign flag is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide (restoring, XLEN iterations):
  - DIV/REM operate on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
- Special cases (decided in IDLE, no iteration):
  - op_b=0: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (DIV/REM with op_a = most-negative, op_b = all ones): DIV → op_a; REM → 0.
- Multiply by zero is not special-cased and takes the full latency.
- result changes only on DONE entry or reset. done is never asserted for two consecutive cycles.

Test Plan (XLEN=32):
- MUL, op_a=7, op_b=0xFFFFFFFD → result=0xFFFFFFEB; done exactly 33 cycles after the start edge; busy=1 for cycles 1–32.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with done in cycle 1 and busy never asserted:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Start DIVU 100/7; pulse start with other operands at cycle 10 → ignored; result=14 at cycle 33. A start held high through DONE launches the next op only from IDLE.
- Start MUL; assert rst at cycle 12 → busy=0, done=0, result=0 the next cycle; no done pulse follows. A fresh MUL 3×4 then yields 12 with the normal latency.
